// File: rtl/memory_board_ctrl_if.sv
// Board-controller bus: button pulses and card labels in, board/score/status view out.
// master = button/label source and renderer side, slave = memory_board_ctrl.
interface memory_board_ctrl_if #(
   parameter int NUM_CARDS   = 16,
   parameter int LABEL_W     = 4,
   parameter int NUM_PLAYERS = 2
);
   localparam int CW = $clog2(NUM_CARDS);
   localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
   localparam int SW = $clog2(NUM_CARDS/2 + 1);

   logic                           move;
   logic                           select;
   logic [NUM_CARDS*LABEL_W-1:0]   labels;
   logic [CW-1:0]                  cursor;
   logic [2*NUM_CARDS-1:0]         card_state;
   logic [PW-1:0]                  player;
   logic [NUM_PLAYERS*SW-1:0]      score;
   logic                           busy;
   logic                           match_pulse;
   logic                           miss_pulse;
   logic                           game_over;

   modport master (
      output move, select, labels,
      input  cursor, card_state, player, score, busy, match_pulse, miss_pulse, game_over
   );

   modport slave (
      input  move, select, labels,
      output cursor, card_state, player, score, busy, match_pulse, miss_pulse, game_over
   );
endinterface

// File: rtl/memory_board_ctrl.sv
// Memory (pairs) game board controller: cursor with skip-to-hidden, two-pick compare,
// timed mismatch display, per-player scoring, turn rotation and end-of-game detection.
module memory_board_ctrl #(
   parameter int NUM_CARDS   = 16,
   parameter int LABEL_W     = 4,
   parameter int NUM_PLAYERS = 2,
   parameter int HOLD_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   memory_board_ctrl_if.slave bus
);
   localparam int CW = $clog2(NUM_CARDS);
   localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
   localparam int SW = $clog2(NUM_CARDS/2 + 1);
   localparam int TW = $clog2(HOLD_CYCLES + 1);
   localparam int unsigned NC = NUM_CARDS;
   localparam int unsigned NP = NUM_PLAYERS;

   typedef enum logic [2:0] {S_PICK1, S_PICK2, S_COMPARE, S_HOLD, S_DONE} state_t;
   typedef enum logic [1:0] {C_HIDDEN = 2'd0, C_SHOWN = 2'd1, C_MATCHED = 2'd2} card_t;

   state_t        state_q;
   card_t         cards_q [NUM_CARDS];
   logic [SW-1:0] score_q [NUM_PLAYERS];
   logic [CW-1:0] cursor_q, sel1_q, sel2_q;
   logic [PW-1:0] player_q;
   logic [TW-1:0] timer_q;
   logic          busy_q, match_q, miss_q, over_q;

   logic [CW-1:0]      nxt_cur_d;
   logic               found_d;
   logic               rest_matched_d;
   logic [LABEL_W-1:0] lab1_d, lab2_d;

   // First HIDDEN card strictly after the cursor, scanning with wrap-around.
   always_comb begin : next_hidden
      int unsigned idx;
      idx       = 0;
      nxt_cur_d = cursor_q;
      found_d   = 1'b0;
      for (int unsigned k = 1; k < NC; k++) begin
         idx = int'(cursor_q) + k;
         if (idx >= NC) idx = idx - NC;
         if (!found_d && cards_q[CW'(idx)] == C_HIDDEN) begin
            nxt_cur_d = CW'(idx);
            found_d   = 1'b1;
         end
      end
   end

   // Every card other than the pair under comparison is already matched.
   always_comb begin
      rest_matched_d = 1'b1;
      for (int unsigned i = 0; i < NC; i++) begin
         if (CW'(i) != sel1_q && CW'(i) != sel2_q && cards_q[CW'(i)] != C_MATCHED)
            rest_matched_d = 1'b0;
      end
   end

   assign lab1_d = bus.labels[int'(sel1_q)*LABEL_W +: LABEL_W];
   assign lab2_d = bus.labels[int'(sel2_q)*LABEL_W +: LABEL_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_PICK1;
         cursor_q <= '0;
         sel1_q   <= '0;
         sel2_q   <= '0;
         player_q <= '0;
         timer_q  <= '0;
         busy_q   <= 1'b0;
         match_q  <= 1'b0;
         miss_q   <= 1'b0;
         over_q   <= 1'b0;
         for (int unsigned i = 0; i < NC; i++) cards_q[i] <= C_HIDDEN;
         for (int unsigned p = 0; p < NP; p++) score_q[p] <= '0;
      end else begin
         match_q <= 1'b0;
         miss_q  <= 1'b0;
         case (state_q)
            S_PICK1, S_PICK2: begin
               // A select pulse always wins over a coincident move, even when it is ignored.
               if (bus.select) begin
                  if (cards_q[cursor_q] == C_HIDDEN) begin
                     cards_q[cursor_q] <= C_SHOWN;
                     if (state_q == S_PICK1) begin
                        sel1_q  <= cursor_q;
                        state_q <= S_PICK2;
                     end else begin
                        sel2_q  <= cursor_q;
                        busy_q  <= 1'b1;
                        state_q <= S_COMPARE;
                     end
                  end
               end else if (bus.move) begin
                  cursor_q <= nxt_cur_d;
               end
            end
            S_COMPARE: begin
               if (lab1_d == lab2_d) begin
                  cards_q[sel1_q] <= C_MATCHED;
                  cards_q[sel2_q] <= C_MATCHED;
                  if (score_q[player_q] != SW'(NUM_CARDS/2))
                     score_q[player_q] <= score_q[player_q] + 1'b1;
                  match_q <= 1'b1;
                  busy_q  <= 1'b0;
                  over_q  <= rest_matched_d;
                  state_q <= rest_matched_d ? S_DONE : S_PICK1;
               end else begin
                  miss_q  <= 1'b1;
                  timer_q <= TW'(HOLD_CYCLES);
                  state_q <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (timer_q == TW'(1)) begin
                  cards_q[sel1_q] <= C_HIDDEN;
                  cards_q[sel2_q] <= C_HIDDEN;
                  player_q <= (player_q == PW'(NUM_PLAYERS - 1)) ? '0 : player_q + 1'b1;
                  timer_q  <= '0;
                  busy_q   <= 1'b0;
                  state_q  <= S_PICK1;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.card_state = '0;
      for (int unsigned i = 0; i < NC; i++) bus.card_state[2*i +: 2] = cards_q[CW'(i)];
   end

   always_comb begin
      bus.score = '0;
      for (int unsigned p = 0; p < NP; p++) bus.score[p*SW +: SW] = score_q[p];
   end

   assign bus.cursor      = cursor_q;
   assign bus.player      = player_q;
   assign bus.busy        = busy_q;
   assign bus.match_pulse = match_q;
   assign bus.miss_pulse  = miss_q;
   assign bus.game_over   = over_q;
endmodule

// File: tb/tb_memory_board_ctrl.sv
// Bench for memory_board_ctrl: a per-cycle expectation table for a full 16-card game
// plus hand-driven sequences for reset after random play and reset in the middle of HOLD.
module tb_memory_board_ctrl;
   localparam int NC = 16;
   localparam int LW = 4;
   localparam int NP = 2;
   localparam int HC = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   memory_board_ctrl_if #(.NUM_CARDS(NC), .LABEL_W(LW), .NUM_PLAYERS(NP)) bus ();

   memory_board_ctrl #(
      .NUM_CARDS(NC), .LABEL_W(LW), .NUM_PLAYERS(NP), .HOLD_CYCLES(HC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic        mv;
      logic        sel;
      logic [3:0]  cur;
      logic [31:0] cs;
      logic        ply;
      logic [7:0]  score;
      logic        busy;
      logic        mp;
      logic        xp;
      logic        ov;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   errors = 0;
   int   checks = 0;

   int lab [NC] = '{1, 3, 2, 4, 5, 6, 7, 8, 6, 3, 7, 4, 8, 1, 5, 2};

   // Expected board while the table is being built.
   int          e_cur;
   logic [15:0] e_sh, e_mt;
   int          e_ply;
   int          e_s [NP];
   logic        e_ov;
   int          p1;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] cs_of(logic [15:0] sh, logic [15:0] mt);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < NC; i++) r[2*i +: 2] = mt[i] ? 2'd2 : (sh[i] ? 2'd1 : 2'd0);
      return r;
   endfunction

   function void add(bit mv, bit sel, bit busy, bit mp, bit xp);
      vec_t v;
      v.mv = mv; v.sel = sel; v.busy = busy; v.mp = mp; v.xp = xp;
      v.cur   = 4'(e_cur);
      v.cs    = cs_of(e_sh, e_mt);
      v.ply   = 1'(e_ply);
      v.score = {4'(e_s[1]), 4'(e_s[0])};
      v.ov    = e_ov;
      vecs.push_back(v);
   endfunction

   function void do_move(int c);
      e_cur = c;
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   function void do_pick1(bit mv);
      e_sh[e_cur] = 1'b1;
      p1 = e_cur;
      add(mv, 1'b1, 1'b0, 1'b0, 1'b0);
   endfunction

   // Second pick plus the compare cycle; on a miss also the HOLD window. Move is held
   // high through COMPARE/HOLD and must have no effect there.
   function void do_pick2();
      e_sh[e_cur] = 1'b1;
      add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      if (lab[p1] == lab[e_cur]) begin
         e_sh[p1] = 1'b0; e_sh[e_cur] = 1'b0;
         e_mt[p1] = 1'b1; e_mt[e_cur] = 1'b1;
         e_s[e_ply]++;
         e_ov = (e_mt == 16'hFFFF);
         add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      end else begin
         add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
         for (int k = 1; k < HC; k++) add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         e_sh[p1] = 1'b0; e_sh[e_cur] = 1'b0;
         e_ply = (e_ply + 1) % NP;
         add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endfunction

   task automatic cycle(input bit mv, input bit sel);
      @(negedge clk);
      bus.move   = mv;
      bus.select = sel;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_state(string tag);
      chk({tag, " cursor"}, 32'(bus.cursor), 32'd0);
      chk({tag, " card_state"}, bus.card_state, 32'd0);
      chk({tag, " player"}, 32'(bus.player), 32'd0);
      chk({tag, " score"}, 32'(bus.score), 32'd0);
      chk({tag, " busy"}, 32'(bus.busy), 32'd0);
      chk({tag, " game_over"}, 32'(bus.game_over), 32'd0);
      chk({tag, " match_pulse"}, 32'(bus.match_pulse), 32'd0);
      chk({tag, " miss_pulse"}, 32'(bus.miss_pulse), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t e;
      rst = 1'b1;
      bus.move = 1'b0;
      bus.select = 1'b0;
      for (int i = 0; i < NC; i++) bus.labels[i*LW +: LW] = 4'(lab[i]);
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("power-on");
      @(negedge clk);
      rst = 1'b0;

      // Random play, then a single reset cycle.
      for (int i = 0; i < 60; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      bus.move = 1'b0;
      bus.select = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_state("rst after play");
      @(negedge clk);
      rst = 1'b0;

      // Full game from reset: player 0 matches (0,13), misses, player 1 takes over, and so on.
      e_cur = 0; e_sh = '0; e_mt = '0; e_ply = 0; e_s[0] = 0; e_s[1] = 0; e_ov = 1'b0;
      do_pick1(1'b0);
      for (int c = 1; c <= 13; c++) do_move(c);
      do_pick2();
      add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      do_move(14); do_move(15); do_move(1);
      do_pick1(1'b0); do_move(2); do_pick2();
      do_pick1(1'b1);
      for (int c = 3; c <= 12; c++) do_move(c);
      do_move(14); do_move(15); do_pick2();
      do_move(1); do_pick1(1'b0);
      for (int c = 3; c <= 9; c++) do_move(c);
      do_pick2();
      do_move(10); do_pick1(1'b0); do_move(11); do_pick2();
      do_pick1(1'b0); do_move(12); do_move(14); do_move(3); do_pick2();
      do_move(4); do_pick1(1'b0);
      for (int c = 5; c <= 8; c++) do_move(c);
      do_move(10); do_move(12); do_move(14); do_pick2();
      do_move(5); do_pick1(1'b0); do_move(6); do_pick2();
      do_pick1(1'b0); do_move(7); do_move(8); do_move(10); do_pick2();
      do_move(12); do_pick1(1'b0); do_move(5); do_move(7); do_pick2();
      do_move(8); do_pick1(1'b0); do_move(5); do_pick2();
      for (int k = 0; k < 3; k++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         @(negedge clk);
         bus.move   = vecs[i].mv;
         bus.select = vecs[i].sel;
         sb.push_back(vecs[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk($sformatf("row%0d cursor", i), 32'(bus.cursor), 32'(e.cur));
         chk($sformatf("row%0d card_state", i), bus.card_state, e.cs);
         chk($sformatf("row%0d player", i), 32'(bus.player), 32'(e.ply));
         chk($sformatf("row%0d score", i), 32'(bus.score), 32'(e.score));
         chk($sformatf("row%0d busy", i), 32'(bus.busy), 32'(e.busy));
         chk($sformatf("row%0d match_pulse", i), 32'(bus.match_pulse), 32'(e.mp));
         chk($sformatf("row%0d miss_pulse", i), 32'(bus.miss_pulse), 32'(e.xp));
         chk($sformatf("row%0d game_over", i), 32'(bus.game_over), 32'(e.ov));
      end
      chk("final score sum", 32'(bus.score[3:0]) + 32'(bus.score[7:4]), 32'd8);

      // Reset in the middle of a HOLD window clears everything, including the pending flip-back.
      @(negedge clk);
      bus.move = 1'b0;
      bus.select = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b0, 1'b1);
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
      chk("hold seq miss_pulse", 32'(bus.miss_pulse), 32'd1);
      cycle(1'b0, 1'b0);
      chk("hold seq busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_state("rst mid-hold");
      @(negedge clk);
      rst = 1'b0;
      repeat (6) cycle(1'b0, 1'b0);
      chk("post-rst card_state", bus.card_state, 32'd0);
      chk("post-rst player", 32'(bus.player), 32'd0);
      chk("post-rst busy", 32'(bus.busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
